latency_credit_fifo: RTL and testbench
======================================

Name: latency_credit_fifo

Overview:
Output buffer for a fixed-latency, non-stallable datapath pipeline, i.e. a chain of delay stages that cannot be stopped. It grants issue slots to the upstream issuer only while buffer space is guaranteed. It captures pipeline results PIPE_LATENCY cycles later and presents them to a ready/valid consumer. Downstream backpressure therefore never drops a result that is already in flight.

Parameters:
BITWIDTH, 8, width of pipeline result data
PIPE_LATENCY, 4, cycles from accepted issue to pipe_valid of the same item (>=1)
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
issue_req  input  1  upstream wants to issue one item into the pipeline
issue_grant  output  1  issue permitted this cycle; issue = issue_req & issue_grant
pipe_valid  input  1  pipeline result present this cycle
pipe_data  input  BITWIDTH  pipeline result
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  BITWIDTH  FIFO head data
level  output  $clog2(DEPTH+1)  current FIFO occupancy
credits  output  $clog2(DEPTH+1)  free slots not yet reserved
err  output  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (rst low, asynchronous): rd/wr pointers 0, level 0, credits DEPTH, err 0, blanking counter loaded with PIPE_LATENCY, out_valid 0. out_data is don't-care while out_valid=0.
- Blanking: for the first PIPE_LATENCY cycles after rst deasserts, issue_grant=0 and pipe_valid is ignored. This discards results of items issued before reset. The counter decrements by 1 per cycle to 0 and does not wrap.
- issue_grant = (credits != 0) & (blanking counter == 0). Combinational from registered state only, with no path from issue_req.
- Credits: -1 on issue, +1 on pop (out_valid & out_ready). Both in the same cycle: no change. Credits + in-flight items + level == DEPTH at all times after blanking.
- Push: pipe_valid (not blanked) writes pipe_data at wr_ptr; wr_ptr+1 mod DEPTH; level+1.
- Pop: out_valid & out_ready; rd_ptr+1 mod DEPTH; level-1.
- Push and pop in the same cycle: both occur, level unchanged. Also legal when level==DEPTH or level==0; an empty FIFO does not bypass, so a push on empty appears at the head next cycle.
- out_valid = (level != 0); out_data = mem[rd_ptr]. Read is combinational from the register array; latency from push to out_valid is 1 cycle.
- Head stability: while out_valid & !out_ready, out_data and out_valid hold.
- Pointers wrap silently at DEPTH-1 -> 0.
- Full push (level==DEPTH & pipe_valid & no pop): write suppressed, no state change except err. Empty pop (out_ready with level==0): no effect.
- Total latency, issue to earliest out_valid: PIPE_LATENCY+1 cycles.

Optional Feature:
- Macro: LATENCY_CREDIT_FIFO_ERR_CHECK_EN.
- Defined: err is set and held until reset on (a) a full push, (b) pipe_valid arriving while no item is in flight, tracked by an in-flight counter, or (c) an issue when issue_grant=0.
- Undefined: err tied 0, the in-flight counter is not built, and the full-push suppression rule still applies.

Test Plan:
- Reset then issue_req=1 constant, pipe echoes issues after 4 cycles with data 0x10,0x11,..., out_ready=1 -> issue_grant 0 for 4 cycles after reset, then 1 every cycle; out_data 0x10.. in order, first out_valid 5 cycles after first issue; credits steady at 3 (8 minus 5 pipeline/FIFO occupants); err 0.
- out_ready=0, issue_req=1 -> exactly 8 grants, then issue_grant 0; level reaches 8 and holds; head stays 0x10; no loss.
- From full, out_ready=1 for one cycle -> level 7, credits 1, one grant next cycle, head 0x11.
- Simultaneous push and pop at level 8 and at level 0 -> level unchanged at 8; level 0 -> 1 with out_valid next cycle; pointers wrap 7->0 with correct data order over 20 items.
- Assert rst low mid-stream with 3 items in flight -> all outputs reset immediately; the 3 stale pipe_valid pulses after release are ignored; level stays 0.
- With LATENCY_CREDIT_FIFO_ERR_CHECK_EN: inject pipe_valid with nothing in flight -> err 1 next cycle and sticky; without the macro -> err stays 0.

Source files
------------

// File: rtl/latency_credit_fifo.sv
// Credit-gated output FIFO behind a fixed-latency, non-stallable pipeline.
// Optional protocol checker: define LATENCY_CREDIT_FIFO_ERR_CHECK_EN to build the sticky err logic.
module latency_credit_fifo #(
    parameter int unsigned BITWIDTH     = 8,
    parameter int unsigned PIPE_LATENCY = 4,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_req,
    output logic                         issue_grant,
    input  logic                         pipe_valid,
    input  logic [BITWIDTH-1:0]          pipe_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITWIDTH-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   credits,
    output logic                         err
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned BW = $clog2(PIPE_LATENCY + 1);

    localparam logic [LW-1:0] DepthL    = LW'(DEPTH);
    localparam logic [LW-1:0] OneL      = LW'(1);
    localparam logic [PW-1:0] OneP      = PW'(1);
    localparam logic [BW-1:0] BlankInit = BW'(PIPE_LATENCY);
    localparam logic [BW-1:0] OneB      = BW'(1);

    logic [BITWIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] credits_q, credits_d;
    logic [BW-1:0] blank_q, blank_d;

    logic blanked;
    logic issue;
    logic pop;
    logic accept;
    logic full;
    logic push;

    // Results of items issued before reset are still in the pipe; hide them until they drain.
    assign blanked     = (blank_q != '0);
    assign issue_grant = (credits_q != '0) && !blanked;
    assign issue       = issue_req && issue_grant;

    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign credits   = credits_q;

    assign pop    = out_valid && out_ready;
    assign accept = pipe_valid && !blanked;
    assign full   = (level_q == DepthL);
    // A simultaneous pop frees the slot, so a push on a full FIFO is legal then.
    assign push   = accept && (!full || pop);

    always_comb begin
        credits_d = credits_q;
        if (issue && !pop) begin
            credits_d = credits_q - OneL;
        end else if (pop && !issue) begin
            credits_d = credits_q + OneL;
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + OneL;
        end else if (pop && !push) begin
            level_d = level_q - OneL;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        blank_d  = blank_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + OneP;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + OneP;
        end
        if (blanked) begin
            blank_d = blank_q - OneB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            credits_q <= DepthL;
            blank_q   <= BlankInit;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            credits_q <= credits_d;
            blank_q   <= blank_d;
        end
    end

    // Storage carries no reset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pipe_data;
        end
    end

`ifdef LATENCY_CREDIT_FIFO_ERR_CHECK_EN
    logic [LW-1:0] inflight_q, inflight_d;
    logic          err_q, err_d;
    logic          err_full;
    logic          err_orphan;
    logic          err_issue;

    assign err_full   = accept && full && !pop;
    assign err_orphan = accept && (inflight_q == '0);
    // Cannot fire while issue is gated by grant; kept so a broken gate is flagged.
    assign err_issue  = issue && !issue_grant;

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !(accept && inflight_q != '0)) begin
            inflight_d = inflight_q + OneL;
        end else if (!issue && accept && inflight_q != '0) begin
            inflight_d = inflight_q - OneL;
        end
        err_d = err_q || err_full || err_orphan || err_issue;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_latency_credit_fifo.sv
// Self-checking bench for latency_credit_fifo: pipe model plus in-order scoreboard.
module tb_latency_credit_fifo;

    localparam int BW    = 8;
    localparam int PL    = 4;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

`ifdef LATENCY_CREDIT_FIFO_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_req = 1'b0;
    logic          issue_grant;
    logic          pipe_valid;
    logic [BW-1:0] pipe_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic [LW-1:0] level;
    logic [LW-1:0] credits;
    logic          err;

    latency_credit_fifo #(
        .BITWIDTH     (BW),
        .PIPE_LATENCY (PL),
        .DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_req   (issue_req),
        .issue_grant (issue_grant),
        .pipe_valid  (pipe_valid),
        .pipe_data   (pipe_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .credits     (credits),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Fixed-latency pipe: an issue sampled before edge T appears as pipe_valid before edge T+PL.
    logic [PL-1:0] pv = '0;
    logic [BW-1:0] pd [PL];
    logic          pend_v = 1'b0;
    logic [BW-1:0] pend_d = '0;
    logic          inj = 1'b0;
    logic [BW-1:0] inj_d = '0;

    assign pipe_valid = pv[PL-1] | inj;
    assign pipe_data  = inj ? inj_d : pd[PL-1];

    always @(posedge clk) begin
        pv    <= {pv[PL-2:0], pend_v};
        pd[0] <= pend_d;
        for (int i = 1; i < PL; i++) pd[i] <= pd[i-1];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_issue = -1;
    int first_ov = -1;
    int n = 0;
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] e;

    // Scoreboard: expected data queued at issue, compared when the consumer takes the head.
    always @(negedge clk) begin
        cyc++;
        pend_v = 1'b0;
        if (issue_req && issue_grant) begin
            pend_v = 1'b1;
            pend_d = 8'h10 + 8'(n);
            exp_q.push_back(pend_d);
            n++;
            if (first_issue < 0) first_issue = cyc;
        end
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out_data=%h, scoreboard empty", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL sb_data: got %h expected %h", out_data, e);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        issue_req = 1'b0;
        out_ready = 1'b0;
        inj = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        repeat (PL + 2) @(posedge clk);
    endtask

    task automatic drain();
        int ok;
        @(posedge clk); #1;
        issue_req = 1'b0;
        out_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (level == '0 && credits == LW'(DEPTH)) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL drain_timeout: level=%0d credits=%0d expected 0/%0d", level, credits, DEPTH);
        end
    endtask

    task automatic test_reset();
        issue_req = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (issue_grant !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b expected 0", issue_grant); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (level !== '0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        if (credits !== LW'(DEPTH)) begin errors++; $display("FAIL rst_credits: got %0d expected %0d", credits, DEPTH); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        first_issue = -1;
        first_ov = -1;
        n = 0;
        exp_q.delete();
        @(posedge clk); #3;
        rst = 1'b1;
        for (int k = 0; k <= PL; k++) begin
            @(negedge clk);
            checks++;
            if (issue_grant !== (k == PL)) begin
                errors++;
                $display("FAIL blank_grant[%0d]: got %b expected %b", k, issue_grant, (k == PL));
            end
        end
    endtask

    task automatic test_stream();
        repeat (25) @(negedge clk);
        checks += 5;
        if (first_issue < 0 || first_ov - first_issue != PL + 1) begin
            errors++;
            $display("FAIL stream_latency: got %0d expected %0d", first_ov - first_issue, PL + 1);
        end
        if (credits !== LW'(3)) begin errors++; $display("FAIL stream_credits: got %0d expected 3", credits); end
        if (level !== LW'(1)) begin errors++; $display("FAIL stream_level: got %0d expected 1", level); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %b expected 1", out_valid); end
        if (err !== 1'b0) begin errors++; $display("FAIL stream_err: got %b expected 0", err); end
    endtask

    task automatic test_fill();
        int grants;
        drain();
        n = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue_req = 1'b1;
        grants = 0;
        repeat (30) begin
            @(negedge clk);
            if (issue_req && issue_grant) grants++;
        end
        checks += 6;
        if (grants != DEPTH) begin errors++; $display("FAIL fill_grants: got %0d expected %0d", grants, DEPTH); end
        if (level !== LW'(DEPTH)) begin errors++; $display("FAIL fill_level: got %0d expected %0d", level, DEPTH); end
        if (credits !== '0) begin errors++; $display("FAIL fill_credits: got %0d expected 0", credits); end
        if (issue_grant !== 1'b0) begin errors++; $display("FAIL fill_grant: got %b expected 0", issue_grant); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b expected 1", out_valid); end
        if (out_data !== 8'h10) begin errors++; $display("FAIL fill_head: got %h expected 10", out_data); end
    endtask

    task automatic test_pop_one();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks += 4;
        if (level !== LW'(DEPTH - 1)) begin errors++; $display("FAIL pop1_level: got %0d expected %0d", level, DEPTH - 1); end
        if (credits !== LW'(1)) begin errors++; $display("FAIL pop1_credits: got %0d expected 1", credits); end
        if (issue_grant !== 1'b1) begin errors++; $display("FAIL pop1_grant: got %b expected 1", issue_grant); end
        if (out_data !== 8'h11) begin errors++; $display("FAIL pop1_head: got %h expected 11", out_data); end
        @(negedge clk);
        checks += 2;
        if (issue_grant !== 1'b0) begin errors++; $display("FAIL pop1_regrant: got %b expected 0", issue_grant); end
        if (credits !== '0) begin errors++; $display("FAIL pop1_credits_after: got %0d expected 0", credits); end
    endtask

    task automatic test_empty_push();
        int got;
        drain();
        @(posedge clk); #1;
        issue_req = 1'b1;
        @(posedge clk); #1;
        issue_req = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pipe_valid) begin
                got = 1;
                break;
            end
        end
        checks += 2;
        if (got == 0) begin errors++; $display("FAIL empty_pipe_timeout: got no pipe_valid, expected one"); end
        if (level !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_before: level=%0d valid=%b expected 0/0", level, out_valid);
        end
        @(negedge clk);
        checks += 2;
        if (level !== LW'(1)) begin errors++; $display("FAIL empty_level: got %0d expected 1", level); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL empty_valid: got %b expected 1", out_valid); end
    endtask

    task automatic test_full_pushpop();
        int ok;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue_req = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (level == LW'(DEPTH)) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        issue_req = 1'b0;
        checks++;
        if (ok == 0) begin errors++; $display("FAIL full_timeout: level=%0d expected %0d", level, DEPTH); end
        // Push with no pop while full must be dropped.
        inj = 1'b1;
        inj_d = 8'hE1;
        @(posedge clk); #1;
        inj = 1'b0;
        @(negedge clk);
        checks += 3;
        if (level !== LW'(DEPTH)) begin errors++; $display("FAIL fullpush_level: got %0d expected %0d", level, DEPTH); end
        if (out_data !== exp_q[0]) begin errors++; $display("FAIL fullpush_head: got %h expected %h", out_data, exp_q[0]); end
        if (err !== ERR_EXP) begin errors++; $display("FAIL fullpush_err: got %b expected %b", err, ERR_EXP); end
        @(posedge clk); #1;
        inj = 1'b1;
        inj_d = 8'hEE;
        out_ready = 1'b1;
        exp_q.push_back(8'hEE);
        @(posedge clk); #1;
        inj = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks += 3;
        if (level !== LW'(DEPTH)) begin errors++; $display("FAIL pushpop8_level: got %0d expected %0d", level, DEPTH); end
        if (out_data !== exp_q[0]) begin errors++; $display("FAIL pushpop8_head: got %h expected %h", out_data, exp_q[0]); end
        if (credits !== LW'(1)) begin errors++; $display("FAIL pushpop8_credits: got %0d expected 1", credits); end
        do_reset();
    endtask

    task automatic test_midstream_reset();
        int stale;
        int bad;
        @(posedge clk); #1;
        issue_req = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        issue_req = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        #1;
        checks += 5;
        if (issue_grant !== 1'b0) begin errors++; $display("FAIL mid_grant: got %b expected 0", issue_grant); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        if (level !== '0) begin errors++; $display("FAIL mid_level: got %0d expected 0", level); end
        if (credits !== LW'(DEPTH)) begin errors++; $display("FAIL mid_credits: got %0d expected %0d", credits, DEPTH); end
        if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err); end
        @(posedge clk); #3;
        rst = 1'b1;
        stale = 0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (pipe_valid) stale++;
            if (level != '0 || out_valid) bad++;
        end
        checks += 2;
        if (stale != 3) begin errors++; $display("FAIL mid_stale_pulses: got %0d expected 3", stale); end
        if (bad != 0) begin errors++; $display("FAIL mid_stale_captured: got %0d nonempty cycles expected 0", bad); end
    endtask

    task automatic test_err();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b expected 0", err); end
        @(posedge clk); #1;
        inj = 1'b1;
        inj_d = 8'h5A;
        out_ready = 1'b1;
        exp_q.push_back(8'h5A);
        @(posedge clk); #1;
        inj = 1'b0;
        @(negedge clk);
        checks += 2;
        if (err !== ERR_EXP) begin errors++; $display("FAIL err_set: got %b expected %b", err, ERR_EXP); end
        if (level !== LW'(1)) begin errors++; $display("FAIL err_level: got %0d expected 1", level); end
        repeat (4) @(negedge clk);
        checks += 2;
        if (err !== ERR_EXP) begin errors++; $display("FAIL err_sticky: got %b expected %b", err, ERR_EXP); end
        if (level !== '0) begin errors++; $display("FAIL err_drained: got %0d expected 0", level); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_pop_one();
        test_empty_push();
        test_full_pushpop();
        test_midstream_reset();
        test_err();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
